// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Brief    : 4x4 active-low matrix keypad scanner with frame-based debounce;
//            emits one keyboard_en strobe and a 4-bit code per accepted press.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       keyboard_en,
    output logic [3:0] keyboard_num,
    output logic       key_held
);

    localparam int c_SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_DCNT_W = $clog2(DEBOUNCE_FRAMES + 1);

    localparam logic [c_SLOT_W-1:0] c_SLOT_LAST = c_SLOT_W'(SCAN_DIV - 1);
    localparam logic [c_DCNT_W-1:0] c_DCNT_DONE = c_DCNT_W'(DEBOUNCE_FRAMES);
    localparam logic [c_DCNT_W-1:0] c_DCNT_ONE  = c_DCNT_W'(1);

    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_DB_PRESS   = 2'd1;
    localparam logic [1:0] c_PRESSED    = 2'd2;
    localparam logic [1:0] c_DB_RELEASE = 2'd3;

    logic [3:0]          r_row_meta;
    logic [3:0]          r_row_sync;
    logic [c_SLOT_W-1:0] r_slot;
    logic [1:0]          r_col_idx;
    logic [1:0]          r_acc;
    logic [3:0]          r_code;
    logic [1:0]          r_state;
    logic [c_DCNT_W-1:0] r_dcnt;
    logic [3:0]          r_cand;
    logic                r_en;
    logic [3:0]          r_num;

    logic                w_slot_last;
    logic                w_frame_end;
    logic [3:0]          w_lows;
    logic [2:0]          w_col_lows;
    logic [1:0]          w_row_idx;
    logic [2:0]          w_sum;
    logic                w_none;
    logic                w_one;
    logic [3:0]          w_frame_code;
    logic [c_DCNT_W-1:0] w_dcnt_inc;

    // Two-stage synchroniser; idle rows read as all-high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
        end else begin
            r_row_meta <= row_in;
            r_row_sync <= r_row_meta;
        end
    end

    assign w_slot_last = (r_slot == c_SLOT_LAST);
    assign w_frame_end = w_slot_last && (r_col_idx == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot    <= '0;
            r_col_idx <= 2'd0;
        end else if (w_slot_last) begin
            r_slot    <= '0;
            r_col_idx <= r_col_idx + 2'd1;
        end else begin
            r_slot    <= r_slot + c_SLOT_W'(1);
        end
    end

    assign col_out = ~(4'b0001 << r_col_idx);

    assign w_lows = ~r_row_sync;

    always_comb begin
        w_col_lows = 3'd0;
        w_row_idx  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            w_col_lows = w_col_lows + {2'b00, w_lows[i]};
            if (w_lows[i]) begin
                w_row_idx = 2'(i);
            end
        end
    end

    // r_acc saturates at 2: only NONE / ONE / MULTI matters per frame
    assign w_sum        = {1'b0, r_acc} + w_col_lows;
    assign w_none       = (w_sum == 3'd0);
    assign w_one        = (w_sum == 3'd1);
    assign w_frame_code = (w_col_lows != 3'd0) ? {w_row_idx, r_col_idx} : r_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= 2'd0;
            r_code <= 4'h0;
        end else if (w_slot_last) begin
            if (w_frame_end) begin
                r_acc  <= 2'd0;
                r_code <= 4'h0;
            end else begin
                r_acc  <= (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
                r_code <= w_frame_code;
            end
        end
    end

    assign w_dcnt_inc = (r_dcnt == '1) ? r_dcnt : r_dcnt + c_DCNT_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_dcnt  <= '0;
            r_cand  <= 4'h0;
            r_en    <= 1'b0;
            r_num   <= 4'h0;
        end else begin
            r_en <= 1'b0;
            if (w_frame_end) begin
                case (r_state)
                    c_IDLE: begin
                        if (w_one) begin
                            if (DEBOUNCE_FRAMES == 1) begin
                                r_num   <= w_frame_code;
                                r_en    <= 1'b1;
                                r_state <= c_PRESSED;
                                r_dcnt  <= '0;
                            end else begin
                                r_cand  <= w_frame_code;
                                r_dcnt  <= c_DCNT_ONE;
                                r_state <= c_DB_PRESS;
                            end
                        end
                    end
                    c_DB_PRESS: begin
                        if (w_one && (w_frame_code == r_cand)) begin
                            if (w_dcnt_inc >= c_DCNT_DONE) begin
                                r_num   <= r_cand;
                                r_en    <= 1'b1;
                                r_state <= c_PRESSED;
                                r_dcnt  <= '0;
                            end else begin
                                r_dcnt  <= w_dcnt_inc;
                            end
                        end else begin
                            r_state <= c_IDLE;
                            r_dcnt  <= '0;
                        end
                    end
                    c_PRESSED: begin
                        if (w_none) begin
                            if (DEBOUNCE_FRAMES == 1) begin
                                r_state <= c_IDLE;
                                r_dcnt  <= '0;
                            end else begin
                                r_state <= c_DB_RELEASE;
                                r_dcnt  <= c_DCNT_ONE;
                            end
                        end
                    end
                    default: begin
                        if (w_none) begin
                            if (w_dcnt_inc >= c_DCNT_DONE) begin
                                r_state <= c_IDLE;
                                r_dcnt  <= '0;
                            end else begin
                                r_dcnt  <= w_dcnt_inc;
                            end
                        end else begin
                            r_state <= c_PRESSED;
                            r_dcnt  <= '0;
                        end
                    end
                endcase
            end
        end
    end

    assign keyboard_en  = r_en;
    assign keyboard_num = r_num;
    assign key_held     = (r_state == c_PRESSED) || (r_state == c_DB_RELEASE);

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scanner
// Brief    : Self-checking bench for keypad_scanner with a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 3;
    localparam int FR = 4 * SD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic        keyboard_en;
    logic [3:0]  keyboard_num;
    logic        key_held;
    logic [15:0] keys = 16'h0;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int          n = 0;
    logic [15:0] k1 = 16'h0;
    logic [15:0] k2 = 16'h0;
    int          acc_cnt = 0;
    int          acc_code = 0;
    logic        exp_en = 1'b0;
    logic [3:0]  exp_num = 4'h0;
    logic        exp_held = 1'b0;
    int          run = 0;
    int          cand = 0;
    int          rel = 0;

    int          strobe_cnt = 0;
    logic [3:0]  first_code = 4'h0;
    logic [3:0]  last_code = 4'h0;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .row_in       (row_in),
        .col_out      (col_out),
        .keyboard_en  (keyboard_en),
        .keyboard_num (keyboard_num),
        .key_held     (key_held)
    );

    always #5 clk = ~clk;

    // keypad: pressed key (r,c) shorts row r to column c
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!col_out[c] && keys[r*4+c]) row_in[r] = 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: n counts clock edges since reset release; a column
    // sample at edge n sees the keypad as it stood two edges earlier.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                n = 0; k1 = 16'h0; k2 = 16'h0; acc_cnt = 0; acc_code = 0;
                exp_en = 1'b0; exp_num = 4'h0; exp_held = 1'b0;
                run = 0; cand = 0; rel = 0;
            end else begin
                n++;
                exp_en = 1'b0;
                if ((n - 1) % SD == SD - 1) begin
                    int c;
                    c = ((n - 1) / SD) % 4;
                    for (int r = 0; r < 4; r++) begin
                        if (k2[r*4+c]) begin
                            acc_cnt++;
                            acc_code = r * 4 + c;
                        end
                    end
                    if (c == 3) begin
                        if (!exp_held) begin
                            if (run == 0) begin
                                if (acc_cnt == 1) begin run = 1; cand = acc_code; end
                            end else if (acc_cnt == 1 && acc_code == cand) begin
                                run++;
                            end else begin
                                run = 0;
                            end
                            if (run >= DB) begin
                                exp_en = 1'b1; exp_num = 4'(cand); exp_held = 1'b1; run = 0;
                            end
                        end else if (acc_cnt == 0) begin
                            rel++;
                            if (rel >= DB) begin exp_held = 1'b0; rel = 0; end
                        end else begin
                            rel = 0;
                        end
                        acc_cnt = 0;
                        acc_code = 0;
                    end
                end
                k2 = k1;
                k1 = keys;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check_eq("rst_en", keyboard_en, 1'b0);
                check_eq("rst_num", keyboard_num, 4'h0);
                check_eq("rst_held", key_held, 1'b0);
                check_eq("rst_col", col_out, 4'b1110);
            end else begin
                logic [3:0] ec;
                ec = 4'hF;
                ec[(n / SD) % 4] = 1'b0;
                check_eq("en", keyboard_en, exp_en);
                check_eq("num", keyboard_num, exp_num);
                check_eq("held", key_held, exp_held);
                check_eq("col", col_out, ec);
                check_eq("col_onehot", $countones(~col_out), 1);
                if (keyboard_en) begin
                    if (strobe_cnt == 0) first_code = keyboard_num;
                    last_code = keyboard_num;
                    strobe_cnt++;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        strobe_cnt = 0;
        rst_n = 1'b1;
    endtask

    task automatic hold(input int frames);
        repeat (frames * FR) @(negedge clk);
    endtask

    function automatic logic [15:0] kbit(input int r, input int c);
        logic [15:0] v;
        v = 16'h0;
        v[r*4+c] = 1'b1;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        keys = 16'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: single clean press and long hold
        do_reset();
        hold(2);
        keys = kbit(1, 2);
        hold(10);
        keys = 16'h0;
        hold(5);
        check_eq("t1_strobes", strobe_cnt, 1);
        check_eq("t1_num", keyboard_num, 4'h6);

        // 2: bouncing contact never reaches the debounce count
        do_reset();
        for (int i = 0; i < 5; i++) begin
            keys = kbit(0, 0);
            hold(2);
            keys = 16'h0;
            hold(1);
        end
        hold(3);
        check_eq("t2_strobes", strobe_cnt, 0);
        check_eq("t2_num", keyboard_num, 4'h0);

        // 3: two keys together, then one released
        do_reset();
        keys = kbit(3, 3) | kbit(0, 1);
        hold(8);
        check_eq("t3_multi_strobes", strobe_cnt, 0);
        keys = kbit(3, 3);
        hold(6);
        check_eq("t3_strobes", strobe_cnt, 1);
        check_eq("t3_num", keyboard_num, 4'hF);
        keys = 16'h0;
        hold(5);

        // 4a: long enough release between presses
        do_reset();
        keys = kbit(1, 2);
        hold(6);
        keys = 16'h0;
        hold(4);
        keys = kbit(2, 0);
        hold(6);
        keys = 16'h0;
        hold(5);
        check_eq("t4a_strobes", strobe_cnt, 2);
        check_eq("t4a_first", first_code, 4'h6);
        check_eq("t4a_last", last_code, 4'h8);

        // 4b: too-short release merges into one hold
        do_reset();
        keys = kbit(1, 2);
        hold(6);
        keys = 16'h0;
        hold(2);
        keys = kbit(2, 0);
        hold(6);
        keys = 16'h0;
        hold(5);
        check_eq("t4b_strobes", strobe_cnt, 1);
        check_eq("t4b_num", keyboard_num, 4'h6);

        // 5: asynchronous reset in the middle of debounce
        do_reset();
        keys = kbit(1, 2);
        repeat (40) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_eq("t5_rst_col", col_out, 4'b1110);
        check_eq("t5_rst_en", keyboard_en, 1'b0);
        check_eq("t5_rst_held", key_held, 1'b0);
        check_eq("t5_rst_num", keyboard_num, 4'h0);
        repeat (2) @(negedge clk);
        strobe_cnt = 0;
        rst_n = 1'b1;
        hold(6);
        check_eq("t5_strobes", strobe_cnt, 1);
        check_eq("t5_num", keyboard_num, 4'h6);
        keys = 16'h0;
        hold(5);

        // 6: idle scanning
        do_reset();
        hold(20);
        check_eq("t6_strobes", strobe_cnt, 0);

        // randomized key activity against the model
        do_reset();
        for (int i = 0; i < 60; i++) begin
            int sel;
            sel = $urandom_range(0, 3);
            case (sel)
                0: keys = 16'h0;
                1, 2: keys = kbit($urandom_range(0, 3), $urandom_range(0, 3));
                default: keys = kbit($urandom_range(0, 3), $urandom_range(0, 3))
                              | kbit($urandom_range(0, 3), $urandom_range(0, 3));
            endcase
            repeat ($urandom_range(8, 120)) @(negedge clk);
        end
        keys = 16'h0;
        hold(5);
        check_eq("rand_idle_held", key_held, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
